// File: rtl/mux_pkg.sv
// Shared constants and helpers for the stream multiplexer slice.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2 for elaboration-time width calculations (value >= 2).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            result = ((32'sd1 <<< i) < value) ? (i + 1) : result;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// modulo CH. Purely combinational; the pointer lives in the parent.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int CH = 4,
    parameter int SW = clog2(CH)
) (
    input  logic [CH-1:0] req,
    input  logic [SW-1:0] ptr,
    output logic [CH-1:0] grant,
    output logic [SW-1:0] grant_idx,
    output logic          any
);

    int idx_s;

    // Rotating priority search starting from ptr.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx_s     = 0;
        for (int i = 0; i < CH; i++) begin
            idx_s = (int'(ptr) + i) % CH;
            if (!any && req[idx_s]) begin
                any          = 1'b1;
                grant_idx    = SW'(idx_s);
                grant[idx_s] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// Stream multiplexer: CH valid/ready input channels into one registered
// output, with fixed-select or round-robin channel choice.
module stream_mux
    import mux_pkg::*;
#(
    parameter  int n  = 32,
    parameter  int CH = 4,
    localparam int SW = clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   in_valid,
    input  logic [CH*n-1:0] in_data,
    output logic [CH-1:0]   in_ready,
    input  logic            mode,
    input  logic [SW-1:0]   sel,
    output logic            out_valid,
    output logic [n-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    input  logic            out_ready
);

    logic          load_s;
    logic [CH-1:0] arb_grant_s;
    logic [SW-1:0] arb_idx_s;
    logic          arb_any_s;
    logic [SW-1:0] grant_idx_s;
    logic          xfer_s;
    logic [n-1:0]  mux_data_s;

    logic          out_valid_r;
    logic [n-1:0]  out_data_r;
    logic [SW-1:0] out_ch_r;
    logic [SW-1:0] ptr_r;

    // The output register can take a beat when empty or being drained.
    assign load_s = !out_valid_r || out_ready;

    rr_arbiter #(
        .CH (CH),
        .SW (SW)
    ) u_arb (
        .req       (in_valid),
        .ptr       (ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s),
        .any       (arb_any_s)
    );

    // Ready generation; fixed mode ignores in_valid so no valid->ready path.
    always_comb begin
        in_ready    = '0;
        grant_idx_s = '0;
        if (mode == MODE_RR) begin
            in_ready    = {CH{load_s && arb_any_s}} & arb_grant_s;
            grant_idx_s = arb_idx_s;
        end else begin
            for (int k = 0; k < CH; k++) begin
                in_ready[k] = load_s && (sel == SW'(k));
            end
            grant_idx_s = sel;
        end
    end

    assign xfer_s = |(in_valid & in_ready);

    // Select the granted channel's data; out-of-range indices yield zero.
    always_comb begin
        mux_data_s = '0;
        for (int k = 0; k < CH; k++) begin
            mux_data_s = (grant_idx_s == SW'(k)) ? in_data[k*n +: n] : mux_data_s;
        end
    end

    // Output holding register: load on input transfer, empty on drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= mux_data_s;
            out_ch_r    <= grant_idx_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner on RR transfers only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= '0;
        end else if (xfer_s && (mode == MODE_RR)) begin
            ptr_r <= (arb_idx_s == SW'(CH - 1)) ? '0 : (arb_idx_s + SW'(1));
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_stream_mux.sv
// Self-checking bench for stream_mux: directed scenarios plus randomized
// traffic checked against a behavioural channel-selection model.
module tb_stream_mux;

    localparam int N  = 8;
    localparam int C4 = 4;
    localparam int C3 = 3;

    logic        clk;
    logic        rst;

    // Four-channel instance
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    // Three-channel instance
    logic [2:0]  in_valid3;
    logic [23:0] in_data3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_ready3;

    int total;
    int bad;

    // Reference model state: the held beat and the round-robin pointer.
    bit       m_valid;
    bit [7:0] m_data;
    int       m_ch;
    int       m_ptr;

    stream_mux #(.n(N), .CH(C4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
    );

    stream_mux #(.n(N), .CH(C3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_valid(out_valid3),
        .out_data(out_data3), .out_ch(out_ch3), .out_ready(out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Which channel may be accepted this cycle, as a ready mask.
    function automatic logic [3:0] exp_ready_f();
        logic [3:0] r;
        int c;
        r = 4'd0;
        if (!(!m_valid || out_ready)) return r;
        if (mode == 1'b0) begin
            r = 4'd1 << sel;
            return r;
        end
        for (int i = 0; i < C4; i++) begin
            c = (m_ptr + i) % C4;
            if (in_valid[c]) begin
                r = 4'd1 << c;
                return r;
            end
        end
        return r;
    endfunction

    // Channel actually transferring this cycle, or -1.
    function automatic int exp_xfer_f();
        logic [3:0] r;
        r = exp_ready_f();
        for (int c = 0; c < C4; c++) begin
            if (r[c] && in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'd0;
        m_ch    = 0;
        m_ptr   = 0;
    endtask

    // Advance one clock and move the model with it (inputs held from negedge).
    task automatic tick();
        int g;
        bit drain;
        g     = exp_xfer_f();
        drain = m_valid && out_ready;
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*8 +: 8];
            m_ch    = g;
            if (mode) m_ptr = (g + 1) % C4;
        end else if (drain) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 4'd0; in_data = 32'd0; mode = 1'b0; sel = 2'd0; out_ready = 1'b0;
        in_valid3 = 3'd0; in_data3 = 24'd0; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        total++;
        if ({out_valid, out_data, out_ch} !== 11'd0) begin
            bad++;
            $display("FAIL reset4 got v=%0b d=%0h ch=%0d want 0/0/0", out_valid, out_data, out_ch);
        end
        total++;
        if ({out_valid3, out_data3, out_ch3} !== 11'd0) begin
            bad++;
            $display("FAIL reset3 got v=%0b d=%0h ch=%0d want 0/0/0", out_valid3, out_data3, out_ch3);
        end
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL reset_load got in_ready=%b want 0001", in_ready);
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        in_data = {8'h3c, 8'ha5, 8'h5a, 8'hc3};
        #1;
        total++;
        if (in_ready !== 4'b0100) begin
            bad++;
            $display("FAIL fixed_ready got %b want 0100", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'ha5 || out_ch !== 2'd2) begin
            bad++;
            $display("FAIL fixed_beat got v=%0b d=%0h ch=%0d want 1/a5/2", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_rr_sequence();
        int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = $urandom;
            tick();
            total++;
            if (out_valid !== 1'b1 || int'(out_ch) != exp_seq[i] || out_data !== m_data) begin
                bad++;
                $display("FAIL rr_seq[%0d] got v=%0b ch=%0d d=%0h want 1/%0d/%0h",
                         i, out_valid, out_ch, out_data, exp_seq[i], m_data);
            end
        end
    endtask

    task automatic test_rr_sparse();
        int exp_ch[2] = '{3, 1};
        logic [3:0] exp_rdy[2];
        exp_rdy[0] = 4'b1000;
        exp_rdy[1] = 4'b0010;
        mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = $urandom;
            #1;
            total++;
            if (in_ready !== exp_rdy[i]) begin
                bad++;
                $display("FAIL rr_sparse_ready[%0d] got %b want %b", i, in_ready, exp_rdy[i]);
            end
            tick();
            total++;
            if (int'(out_ch) != exp_ch[i] || out_data !== m_data) begin
                bad++;
                $display("FAIL rr_sparse_ch[%0d] got ch=%0d d=%0h want %0d/%0h",
                         i, out_ch, out_data, exp_ch[i], m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        in_data = {24'h000000, 8'h11};
        tick();
        out_ready = 1'b0;
        in_data = {24'h000000, 8'h22};
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL stall_ready[%0d] got %b want 0000", i, in_ready);
            end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 2'd0) begin
                bad++;
                $display("FAIL stall_hold[%0d] got v=%0b d=%0h ch=%0d want 1/11/0",
                         i, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL release_ready got %b want 0001", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            bad++;
            $display("FAIL release_beat got v=%0b d=%0h want 1/22", out_valid, out_data);
        end
    endtask

    task automatic test_sel_oob();
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = 24'habcdef;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (in_ready3 !== 3'b000) begin
                bad++;
                $display("FAIL oob_ready[%0d] got %b want 000", i, in_ready3);
            end
            @(posedge clk); @(negedge clk);
            total++;
            if (out_valid3 !== 1'b0) begin
                bad++;
                $display("FAIL oob_valid[%0d] got %0b want 0", i, out_valid3);
            end
        end
        sel3 = 2'd1;
        #1;
        total++;
        if (in_ready3 !== 3'b010) begin
            bad++;
            $display("FAIL sel3_ready got %b want 010", in_ready3);
        end
        @(posedge clk); @(negedge clk);
        total++;
        if (out_valid3 !== 1'b1 || out_data3 !== 8'hcd || out_ch3 !== 2'd1) begin
            bad++;
            $display("FAIL sel3_beat got v=%0b d=%0h ch=%0d want 1/cd/1", out_valid3, out_data3, out_ch3);
        end
        in_valid3 = 3'd0;
    endtask

    task automatic test_reset_mid();
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1; in_data = $urandom;
        tick();
        out_ready = 1'b0; in_valid = 4'b0000;
        tick();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        total++;
        if ({out_valid, out_data, out_ch} !== 11'd0) begin
            bad++;
            $display("FAIL midreset got v=%0b d=%0h ch=%0d want 0/0/0", out_valid, out_data, out_ch);
        end
        @(negedge clk);
        rst = 1'b1;
        in_valid = 4'b1111; out_ready = 1'b0; in_data = $urandom;
        #1;
        total++;
        if (in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL midreset_ready got %b want 0001", in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== m_data) begin
            bad++;
            $display("FAIL midreset_first got v=%0b ch=%0d d=%0h want 1/0/%0h",
                     out_valid, out_ch, out_data, m_data);
        end
    endtask

    task automatic test_random();
        logic [3:0] er;
        for (int i = 0; i < 300; i++) begin
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            er = exp_ready_f();
            total++;
            if (in_ready !== er) begin
                bad++;
                $display("FAIL rand_ready[%0d] got %b want %b", i, in_ready, er);
            end
            tick();
            total++;
            if (out_valid !== m_valid ||
                (m_valid && (out_data !== m_data || int'(out_ch) != m_ch))) begin
                bad++;
                $display("FAIL rand_out[%0d] got v=%0b d=%0h ch=%0d want %0b/%0h/%0d",
                         i, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fixed();
        test_rr_sequence();
        test_rr_sparse();
        test_backpressure();
        test_sel_oob();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 SHALL have parameter n, default 32: data width per channel in bits, n >= 1.
REQ-002 SHALL have parameter CH, default 4: number of input channels, 2 <= CH <= 16.
REQ-003 SHALL have derived localparam SW = clog2(CH): select and channel-id width.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, CH: per-channel valid.
REQ-007 SHALL have port in_data, input, CH*n: channel k data at bits [k*n +: n].
REQ-008 SHALL have port in_ready, output, CH: per-channel ready (combinational).
REQ-009 SHALL have port mode, input, 1: 0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port sel, input, SW: channel index used in fixed mode.
REQ-011 SHALL have port out_valid, output, 1: output register holds a beat.
REQ-012 SHALL have port out_data, output, n: registered beat data.
REQ-013 SHALL have port out_ch, output, SW: source channel of the held beat.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts beat.

Function
REQ-015 SHALL define a transfer on channel k as in_valid[k] && in_ready[k] at a rising edge, and an output transfer as out_valid && out_ready.
REQ-016 SHALL compute load = !out_valid || out_ready; at most one in_ready bit may be 1, and only when load = 1.
REQ-017 In fixed mode, SHALL assert in_ready[sel] = load and all other bits 0; if sel >= CH, all in_ready = 0.
REQ-018 In round-robin mode, SHALL grant the first valid channel searching ptr, ptr+1, ... modulo CH; in_ready[grant] = load, all others 0.
REQ-019 SHALL load out_data/out_ch from the granted channel on an input transfer, setting out_valid = 1 the next cycle (latency 1).
REQ-020 SHALL clear out_valid on an output transfer when no input transfer occurs in the same cycle.
REQ-021 Simultaneous output and input transfer SHALL replace the beat with no bubble (one beat per cycle sustained).
REQ-022 While out_valid && !out_ready, out_data and out_ch SHALL remain stable.
REQ-023 SHALL update ptr to (grant+1) mod CH only on a round-robin input transfer; ptr wraps CH-1 -> 0.
REQ-024 SHALL leave ptr unchanged in fixed mode and on cycles with no transfer.
REQ-025 mode and sel SHALL be sampled every cycle; a change takes effect on the next grant and never alters a held beat.
REQ-026 in_ready SHALL NOT depend on in_valid of the same channel in fixed mode (no combinational valid->ready loop).

Reset
REQ-027 While rst = 0, SHALL force out_valid = 0, out_data = 0, out_ch = 0, ptr = 0, asynchronously.
REQ-028 Reset mid-beat SHALL discard the held beat; the first cycle after release SHALL show load = 1.

Structure
REQ-029 SHALL place the clog2 function and the MODE_FIXED/MODE_RR constants in a shared package, mux_pkg.
REQ-030 SHALL implement round-robin grant in one sub-module, rr_arbiter (inputs req, ptr; output grant one-hot plus index, any).
REQ-031 SHALL contain exactly one register stage (the output register plus ptr); no other state.

Verification
REQ-032 Fixed mode, CH=4, sel=2, in_valid=4'b1111, in_data[2]=0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xA5, out_ch=2.
REQ-033 RR mode, all valid, out_ready=1, 6 cycles -> out_ch sequence 0,1,2,3,0,1; ptr wraps 3 -> 0.
REQ-034 RR mode, only ch1 and ch3 valid, ptr=2 -> grant 3 then 1; out_ch 3,1.
REQ-035 out_ready=0 for 3 cycles with beat 0x11 held -> in_ready=0, out_data stays 0x11; release -> new beat next cycle, no bubble.
REQ-036 Fixed mode, CH=3, sel=3 -> in_ready=0 and out_valid stays 0.
REQ-037 rst pulled low while out_valid=1, ptr=2 -> out_valid=0, ptr=0 immediately; after release RR grants ch0 first.
